// File: rtl/tlc5615_pkg.sv
// -----------------------------------------------------------------------------
// tlc5615_pkg
// Shared constants and types for the TLC5615 serial-DAC transmitter.
//   FRAME_LEN : bits shifted per DAC write (data + pad)
//   DATA_W    : DAC sample width
//   PAD_BITS  : trailing zero bits the DAC ignores
//   state_t   : transmitter FSM state encoding
//   frame_of  : builds the MSB-first frame word from a sample
// -----------------------------------------------------------------------------
package tlc5615_pkg;

  localparam int FRAME_LEN = 12;
  localparam int DATA_W    = 10;
  localparam int PAD_BITS  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TRAIL = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Sample followed by the zero pad bits, ready to shift out MSB first.
  function automatic logic [FRAME_LEN-1:0] frame_of(input logic [DATA_W-1:0] d);
    return {d, {PAD_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/tlc5615_tick_gen.sv
// -----------------------------------------------------------------------------
// tlc5615_tick_gen
// Half-period pacing for SCLK. An 8-bit counter runs while `run` is high and
// flags `tick` on the cycle it holds CLK_DIV-1, then wraps to 0.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   run   : count enable (transmitter outside IDLE)
//   clear : synchronous counter clear (frame accept)
//   tick  : one-cycle strobe, one per CLK_DIV enabled cycles
// -----------------------------------------------------------------------------
module tlc5615_tick_gen #(
  parameter int CLK_DIV = 120
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;

  // Divider counter: cleared on accept, advances only while running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 8'd0;
    end else if (clear) begin
      r_cnt <= 8'd0;
    end else if (run) begin
      if (r_cnt == LAST) begin
        r_cnt <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Decoded from the counter register; the FSM consumes it on the same edge
  // the counter wraps, so edges land exactly CLK_DIV cycles apart.
  assign tick = run && (r_cnt == LAST);

endmodule

// File: rtl/tlc5615_drive.sv
// -----------------------------------------------------------------------------
// tlc5615_drive
// Serial transmitter for the TLC5615 10-bit DAC. Takes one sample per
// valid/ready handshake and sends the 12-bit frame {din, 2'b00} MSB first on
// CS/SCLK/DIN, paced by tlc5615_tick_gen. All outputs are registered.
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   din_valid : sample offered on din
//   din       : 10-bit unsigned sample
//   din_ready : transmitter idle, sample will be accepted
//   done      : one-cycle pulse after the frame and CS-high gap
//   cs        : DAC chip select, active low
//   sclk      : DAC serial clock, idles low
//   sdo       : DAC serial data (to DAC DIN pin)
// -----------------------------------------------------------------------------
module tlc5615_drive #(
  parameter int CLK_DIV   = 120,
  parameter int GAP_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din_valid,
  input  logic [9:0] din,
  output logic       din_ready,
  output logic       done,
  output logic       cs,
  output logic       sclk,
  output logic       sdo
);

  import tlc5615_pkg::*;

  localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);
  localparam logic [3:0] LAST_GAP = 4'(GAP_TICKS - 1);

  state_t                 r_state;
  logic [FRAME_LEN-1:0]   r_shift;
  logic [3:0]             r_bit_cnt;
  logic [3:0]             r_gap_cnt;
  logic                   r_cs;
  logic                   r_sclk;
  logic                   r_sdo;
  logic                   r_din_ready;
  logic                   r_done;

  logic                   w_accept;
  logic                   w_run;
  logic                   w_tick;

  assign w_accept = din_valid && r_din_ready && (r_state == ST_IDLE);
  assign w_run    = (r_state != ST_IDLE);

  tlc5615_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .run   (w_run),
    .clear (w_accept),
    .tick  (w_tick)
  );

  // Transmitter FSM with shift register, bit/gap counters and output regs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= {FRAME_LEN{1'b0}};
      r_bit_cnt   <= 4'd0;
      r_gap_cnt   <= 4'd0;
      r_cs        <= 1'b1;
      r_sclk      <= 1'b0;
      r_sdo       <= 1'b0;
      r_din_ready <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shift     <= frame_of(din);
            r_sdo       <= din[9];
            r_cs        <= 1'b0;
            r_din_ready <= 1'b0;
            r_bit_cnt   <= 4'd0;
            r_state     <= ST_LEAD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LEAD: begin
          if (w_tick) begin
            r_sclk  <= 1'b1;
            r_state <= ST_SHIFT;
          end else begin
            r_state <= ST_LEAD;
          end
        end
        ST_SHIFT: begin
          if (w_tick) begin
            if (r_sclk) begin
              // Falling edge: present the next bit so it has a full
              // half-period of setup before the following rise.
              r_sclk    <= 1'b0;
              r_shift   <= {r_shift[FRAME_LEN-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == LAST_BIT) begin
                r_sdo   <= 1'b0;
                r_state <= ST_TRAIL;
              end else begin
                r_sdo   <= r_shift[FRAME_LEN-2];
                r_state <= ST_SHIFT;
              end
            end else begin
              r_sclk <= 1'b1;
            end
          end else begin
            r_state <= ST_SHIFT;
          end
        end
        ST_TRAIL: begin
          if (w_tick) begin
            r_cs      <= 1'b1;
            r_gap_cnt <= 4'd0;
            r_state   <= ST_GAP;
          end else begin
            r_state <= ST_TRAIL;
          end
        end
        ST_GAP: begin
          if (w_tick) begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
            // The tick that brings the count to GAP_TICKS ends the gap.
            if (r_gap_cnt == LAST_GAP) begin
              r_din_ready <= 1'b1;
              r_done      <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_state <= ST_GAP;
            end
          end else begin
            r_state <= ST_GAP;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cs        <= 1'b1;
          r_sclk      <= 1'b0;
          r_sdo       <= 1'b0;
          r_din_ready <= 1'b1;
        end
      endcase
    end
  end

  assign din_ready = r_din_ready;
  assign done      = r_done;
  assign cs        = r_cs;
  assign sclk      = r_sclk;
  assign sdo       = r_sdo;

endmodule

// File: tb/tb_tlc5615_drive.sv
// -----------------------------------------------------------------------------
// tb_tlc5615_drive
// Self-checking bench for tlc5615_drive with CLK_DIV=4, GAP_TICKS=2.
// A pin-level monitor reconstructs every frame and its timing from the DAC
// pins and compares against values computed from the frame rules.
// -----------------------------------------------------------------------------
module tb_tlc5615_drive;

  localparam int D = 4;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din_valid = 1'b0;
  logic [9:0] din = 10'd0;
  logic       din_ready;
  logic       done;
  logic       cs;
  logic       sclk;
  logic       sdo;

  always #5 clk = ~clk;

  tlc5615_drive #(
    .CLK_DIV   (D),
    .GAP_TICKS (G)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din_valid (din_valid),
    .din       (din),
    .din_ready (din_ready),
    .done      (done),
    .cs        (cs),
    .sclk      (sclk),
    .sdo       (sdo)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Reference: the frame is the sample times four in a 12-bit word.
  function automatic logic [11:0] model(input logic [9:0] v);
    int f;
    f = int'(v) * 4;
    return 12'(f);
  endfunction

  // ---------------- pin monitor ----------------
  int          cyc = 0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_sdo = 1'b0;
  logic        prev_done = 1'b0;
  bit          in_frame = 1'b0;
  logic [11:0] bits = 12'd0;
  int          rises = 0;
  int          fall_cyc = 0;
  int          done_cnt = 0;
  int          acc_cnt = 0;
  int          fall_q[$];
  int          rise_q[$];
  logic [11:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [11:0] e;
    if (!reset) begin
      in_frame = 1'b0;
    end else begin
      if (sclk !== prev_sclk) check("sclk_only_while_cs_low", int'(prev_cs | cs), 0);
      if (cs !== prev_cs) check("sclk_low_at_cs_edge", int'(sclk | prev_sclk), 0);
      if (!prev_cs && !cs && (sdo !== prev_sdo))
        check("sdo_changes_only_at_fall", int'(prev_sclk & ~sclk), 1);
      if (done) check("done_single_cycle", int'(prev_done), 0);
      if (prev_cs && !cs) begin
        in_frame = 1'b1;
        fall_cyc = cyc;
        bits     = 12'd0;
        rises    = 0;
        acc_cnt++;
        fall_q.push_back(cyc);
      end
      if (in_frame && sclk && !prev_sclk) begin
        bits = {bits[10:0], sdo};
        rises++;
        check("sclk_rise_time", cyc - fall_cyc, (2 * rises - 1) * D);
      end
      if (in_frame && cs && !prev_cs) begin
        in_frame = 1'b0;
        rise_q.push_back(cyc);
        check("cs_low_cycles", cyc - fall_cyc, 25 * D);
        check("sclk_rises_per_frame", rises, 12);
        check("frame_expected", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("frame_bits", int'(bits), int'(e));
        end
      end
      if (done) begin
        done_cnt++;
        check("done_latency", cyc - fall_cyc, (25 + G) * D);
      end
    end
    prev_cs   = cs;
    prev_sclk = sclk;
    prev_sdo  = sdo;
    prev_done = done;
  end

  // ---------------- stimulus helpers ----------------
  int exp_done = 0;
  int exp_acc  = 0;

  task automatic send(input logic [9:0] v, input logic [11:0] e, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    din       = v;
    din_valid = 1'b1;
    while (!din_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("accept_timeout", 1, 0);
    exp_q.push_back(e);
    @(negedge clk);
    if (!hold) din_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("done_count", done_cnt, target);
  endtask

  typedef struct {
    logic [9:0]  din;
    logic [11:0] exp;
    bit          hold;
  } vec_t;

  vec_t tv[5];

  initial begin
    logic [9:0] v;
    int k;
    int r;

    tv[0] = '{din: 10'h2A5, exp: 12'hA94, hold: 1'b0};
    tv[1] = '{din: 10'h3FF, exp: 12'hFFC, hold: 1'b1};
    tv[2] = '{din: 10'h000, exp: 12'h000, hold: 1'b0};
    tv[3] = '{din: 10'h200, exp: 12'h800, hold: 1'b0};
    tv[4] = '{din: 10'h001, exp: 12'h004, hold: 1'b0};

    #1 reset = 1'b0;
    #11;
    check("rst_cs", int'(cs), 1);
    check("rst_sclk", int'(sclk), 0);
    check("rst_sdo", int'(sdo), 0);
    check("rst_din_ready", int'(din_ready), 1);
    check("rst_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame, back-to-back pair and edge values.
    for (int i = 0; i < 5; i++) begin
      send(tv[i].din, tv[i].exp, tv[i].hold);
      exp_done++;
      exp_acc++;
      if (!tv[i].hold) begin
        wait_done(exp_done);
        if (i == 2) begin
          k = fall_q.size();
          r = rise_q.size();
          check("b2b_accept_spacing", fall_q[k-1] - fall_q[k-2], (25 + G) * D + 1);
          check("b2b_cs_high_cycles", fall_q[k-1] - rise_q[r-2], G * D + 1);
        end
      end
    end

    // Input activity during a frame must be ignored.
    v = 10'($urandom);
    send(v, model(v), 1'b0);
    exp_done++;
    exp_acc++;
    repeat (90) begin
      @(negedge clk);
      din       = 10'($urandom);
      din_valid = 1'($urandom);
    end
    din_valid = 1'b0;
    wait_done(exp_done);
    check("ignored_no_extra_accept", acc_cnt, exp_acc);

    // Reset in the middle of a frame.
    send(10'h155, model(10'h155), 1'b0);
    exp_acc++;
    void'(exp_q.pop_back());
    repeat (49) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_cs", int'(cs), 1);
    check("midrst_sclk", int'(sclk), 0);
    check("midrst_sdo", int'(sdo), 0);
    check("midrst_din_ready", int'(din_ready), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (150) @(negedge clk);
    check("postrst_din_ready", int'(din_ready), 1);
    check("postrst_no_done", done_cnt, exp_done);
    v = 10'($urandom);
    send(v, model(v), 1'b0);
    exp_done++;
    exp_acc++;
    wait_done(exp_done);

    // Randomized frames against the reference model.
    repeat (6) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      v = 10'($urandom);
      send(v, model(v), 1'b0);
      exp_done++;
      exp_acc++;
      wait_done(exp_done);
    end

    repeat (20) @(negedge clk);
    check("total_done", done_cnt, exp_done);
    check("total_accepts", acc_cnt, exp_acc);
    check("pending_frames", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
